// File: rtl/kbd_spart_bridge.sv
// Keyboard-to-SPART bridge: buffers PS/2 set-2 scancodes, translates them to ASCII
// (or hex pairs) and writes them to the SPART, programming its baud generator first.
module kbd_spart_bridge #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RAW_HEX    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          kbd_rda,
  input  logic [7:0]                    kbd_data,
  output logic                          kbd_clear,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  function automatic logic [15:0] f_div(input longint unsigned baud);
    return 16'((64'(CLK_HZ) + 64'd8 * baud) / (64'd16 * baud) - 64'd1);
  endfunction

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  localparam logic [15:0] DIV_4800  = f_div(4800);
  localparam logic [15:0] DIV_9600  = f_div(9600);
  localparam logic [15:0] DIV_19200 = f_div(19200);
  localparam logic [15:0] DIV_38400 = f_div(38400);

  typedef enum logic [2:0] {
    BRG_HI, BRG_LO, IDLE, DECODE, EMIT1, EMIT2, TXGAP
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_cfg_q;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic        r_kbd_clear;
  logic [7:0]  r_cur, r_ch1, r_ch2;
  logic        r_has2, r_shift, r_brk;

  logic        w_full, w_empty, w_push, w_pop, w_cfg_chg, w_is_shift;
  logic        w_emit, w_brk_nx, w_shift_nx;
  logic [7:0]  w_ch, w_wdata;
  logic [15:0] w_div;

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = kbd_rda & ~r_kbd_clear & ~w_full;
  assign w_cfg_chg  = (br_cfg != r_cfg_q);
  assign w_pop      = (r_state == IDLE) & ~w_cfg_chg & ~w_empty;
  assign w_is_shift = (r_cur == 8'h12) || (r_cur == 8'h59);

  // Intake runs independently of the FSM; a full FIFO simply leaves the byte pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_kbd_clear <= 1'b0;
    end else begin
      r_kbd_clear <= w_push;
      if (w_push) begin
        r_mem[r_wptr] <= kbd_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    case (r_cfg_q)
      2'b00:   w_div = DIV_4800;
      2'b01:   w_div = DIV_9600;
      2'b10:   w_div = DIV_19200;
      default: w_div = DIV_38400;
    endcase
  end

  always_comb begin
    w_emit     = 1'b0;
    w_ch       = 8'h2D;
    w_brk_nx   = r_brk;
    w_shift_nx = r_shift;
    if (RAW_HEX != 0) begin
      w_emit = 1'b1;
      w_ch   = f_hex(r_cur[7:4]);
    end else if (r_cur == 8'hF0) begin
      w_brk_nx = 1'b1;
    end else if (r_cur == 8'hE0) begin
      w_brk_nx = r_brk;
    end else if (r_brk) begin
      w_brk_nx = 1'b0;
      if (w_is_shift) w_shift_nx = 1'b0;
    end else if (w_is_shift) begin
      w_shift_nx = 1'b1;
    end else begin
      w_emit = 1'b1;
      case (r_cur)
        8'h1D:   w_ch = r_shift ? 8'h57 : 8'h77;
        8'h1C:   w_ch = r_shift ? 8'h41 : 8'h61;
        8'h1B:   w_ch = r_shift ? 8'h53 : 8'h73;
        8'h23:   w_ch = r_shift ? 8'h44 : 8'h64;
        8'h29:   w_ch = 8'h20;
        8'h5A:   w_ch = 8'h0D;
        default: w_ch = 8'h2D;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= 1'b0;
      r_brk   <= 1'b0;
      r_has2  <= 1'b0;
      r_cfg_q <= br_cfg;
    end else begin
      if (r_state == IDLE && w_cfg_chg) r_cfg_q <= br_cfg;
      if (w_pop) r_cur <= r_mem[r_rptr];
      if (r_state == DECODE) begin
        r_brk   <= w_brk_nx;
        r_shift <= w_shift_nx;
        r_ch1   <= w_ch;
        r_ch2   <= f_hex(r_cur[3:0]);
        r_has2  <= (RAW_HEX != 0);
      end
      if (r_state == EMIT2 && tbr) r_has2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= BRG_HI;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      BRG_HI: w_next = BRG_LO;
      BRG_LO: w_next = IDLE;
      IDLE: begin
        if (w_cfg_chg)     w_next = BRG_HI;
        else if (!w_empty) w_next = DECODE;
      end
      DECODE: w_next = w_emit ? EMIT1 : IDLE;
      EMIT1:  if (tbr) w_next = TXGAP;
      EMIT2:  if (tbr) w_next = TXGAP;
      TXGAP:  w_next = r_has2 ? EMIT2 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced idle combinationally so the bus is quiet for the whole reset cycle.
  always_comb begin
    iocs    = 1'b0;
    iorw    = 1'b1;
    ioaddr  = 2'b00;
    w_wdata = '0;
    if (!rst) begin
      case (r_state)
        BRG_HI: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; w_wdata = w_div[15:8];
        end
        BRG_LO: begin
          iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b10; w_wdata = w_div[7:0];
        end
        EMIT1: if (tbr) begin
          iocs = 1'b1; iorw = 1'b0; w_wdata = r_ch1;
        end
        EMIT2: if (tbr) begin
          iocs = 1'b1; iorw = 1'b0; w_wdata = r_ch2;
        end
        default: iocs = 1'b0;
      endcase
    end
  end

  assign databus    = (iocs & ~iorw) ? w_wdata : 'z;
  assign kbd_clear  = r_kbd_clear & ~rst;
  assign fifo_level = rst ? '0 : r_count;

endmodule
